// File: rtl/regfile_reader_if.sv
// Signal bundle between the register-file scanner and its surroundings:
// scan control, register-file read port, captured data and status.
interface regfile_reader_if;
  logic        Start;
  logic        Stop;
  logic [4:0]  First_Addr;
  logic [4:0]  Last_Addr;
  logic [4:0]  R_Addr_A;
  logic [4:0]  R_Addr_B;
  logic [31:0] R_Data_A;
  logic [31:0] R_Data_B;
  logic [1:0]  C1;
  logic        C2;
  logic [7:0]  LED;
  logic [31:0] Cap_A;
  logic [31:0] Cap_B;
  logic        Valid;
  logic        B_Valid;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [31:0] Checksum;

  modport slave (
    input  Start, Stop, First_Addr, Last_Addr, R_Data_A, R_Data_B, C1, C2,
    output R_Addr_A, R_Addr_B, LED, Cap_A, Cap_B, Valid, B_Valid, Busy, Done,
           Err, Checksum
  );

  modport master (
    output Start, Stop, First_Addr, Last_Addr, R_Data_A, R_Data_B, C1, C2,
    input  R_Addr_A, R_Addr_B, LED, Cap_A, Cap_B, Valid, B_Valid, Busy, Done,
           Err, Checksum
  );
endinterface

// File: rtl/regfile_reader.sv
// Scans a register-file address range two registers at a time, capturing each
// pair, holding it for DWELL cycles, and XOR-accumulating the in-range words.
module regfile_reader #(
  parameter int DWELL = 4
) (
  input logic            Clk,
  input logic            Reset,
  regfile_reader_if.slave bus
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (DWELL > 0) ? CNT_W'(DWELL - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPTURE,
    S_DWELL,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [4:0]       addr_a, addr_b;
  logic [31:0]      cap_a, cap_b, checksum;
  logic [CNT_W-1:0] cnt;
  logic             vld_p1, b_valid, err;

  logic busy, b_in_range, last_pair;
  logic do_start, do_err, do_capture, do_advance;

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] sel);
    case (sel)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  endfunction

  assign busy       = (state == S_ADDR) || (state == S_CAPTURE) || (state == S_DWELL);
  assign b_in_range = addr_a < bus.Last_Addr;
  // Widened so that address 31 cannot wrap the comparison back to zero.
  assign last_pair  = ({1'b0, addr_a} + 6'd1) >= {1'b0, bus.Last_Addr};

  always_comb begin
    state_nxt  = state;
    do_start   = 1'b0;
    do_err     = 1'b0;
    do_capture = 1'b0;
    do_advance = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.Start) begin
          if (bus.First_Addr <= bus.Last_Addr) begin
            do_start  = 1'b1;
            state_nxt = S_ADDR;
          end else begin
            do_err    = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_ADDR: state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        do_capture = 1'b1;
        if (DWELL == 0) begin
          if (last_pair) begin
            state_nxt = S_DONE;
          end else begin
            do_advance = 1'b1;
            state_nxt  = S_ADDR;
          end
        end else begin
          state_nxt = S_DWELL;
        end
      end
      S_DWELL: begin
        if (cnt == '0) begin
          if (last_pair) begin
            state_nxt = S_DONE;
          end else begin
            do_advance = 1'b1;
            state_nxt  = S_ADDR;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort beats every other transition and suppresses the capture it would cut short.
    if (busy && bus.Stop) begin
      state_nxt  = S_IDLE;
      do_capture = 1'b0;
      do_advance = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      addr_a   <= '0;
      addr_b   <= 5'd1;
      cap_a    <= '0;
      cap_b    <= '0;
      checksum <= '0;
      cnt      <= '0;
      vld_p1   <= 1'b0;
      b_valid  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= do_capture;
      if (do_start) begin
        addr_a   <= bus.First_Addr;
        addr_b   <= bus.First_Addr + 5'd1;
        checksum <= '0;
        err      <= 1'b0;
      end
      if (do_err) begin
        err      <= 1'b1;
        checksum <= '0;
      end
      if (do_capture) begin
        cap_a    <= bus.R_Data_A;
        cap_b    <= bus.R_Data_B;
        b_valid  <= b_in_range;
        checksum <= checksum ^ bus.R_Data_A ^ (b_in_range ? bus.R_Data_B : 32'd0);
        cnt      <= CNT_LOAD;
      end else if (state == S_DWELL && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (do_advance) begin
        addr_a <= addr_a + 5'd2;
        addr_b <= addr_a + 5'd3;
      end
    end
  end

  assign bus.R_Addr_A = addr_a;
  assign bus.R_Addr_B = addr_b;
  assign bus.Cap_A    = cap_a;
  assign bus.Cap_B    = cap_b;
  assign bus.Checksum = checksum;
  assign bus.Valid    = vld_p1;
  assign bus.B_Valid  = b_valid;
  assign bus.Err      = err;
  assign bus.Busy     = busy;
  assign bus.Done     = (state == S_DONE);
  assign bus.LED      = byte_sel(bus.C2 ? cap_b : cap_a, bus.C1);

endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: a DWELL=4 and a DWELL=0 instance share stimulus and
// are checked cycle by cycle against a scan model derived from the address range.
module tb_regfile_reader;

  localparam int NONE = 1000000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start, stop, c2;
  logic [4:0]  first_a, last_a;
  logic [1:0]  c1;
  logic [31:0] mem [32];

  int n_vec = 0;
  int n_miscmp = 0;

  int          sc_first, sc_last, sc_stop;
  bit          sc_err;
  logic [31:0] exp_ca [2];
  logic [31:0] exp_cb [2];
  logic [31:0] exp_cs [2];
  logic        exp_bv [2];
  logic        exp_er [2];

  always #5 Clk = ~Clk;

  regfile_reader_if bus4 ();
  regfile_reader_if bus0 ();

  assign bus4.Start      = start;
  assign bus4.Stop       = stop;
  assign bus4.First_Addr = first_a;
  assign bus4.Last_Addr  = last_a;
  assign bus4.C1         = c1;
  assign bus4.C2         = c2;
  assign bus4.R_Data_A   = mem[bus4.R_Addr_A];
  assign bus4.R_Data_B   = mem[bus4.R_Addr_B];
  assign bus0.Start      = start;
  assign bus0.Stop       = stop;
  assign bus0.First_Addr = first_a;
  assign bus0.Last_Addr  = last_a;
  assign bus0.C1         = c1;
  assign bus0.C2         = c2;
  assign bus0.R_Data_A   = mem[bus0.R_Addr_A];
  assign bus0.R_Data_B   = mem[bus0.R_Addr_B];

  regfile_reader #(.DWELL(4)) u_d4 (.Clk(Clk), .Reset(Reset), .bus(bus4.slave));
  regfile_reader #(.DWELL(0)) u_d0 (.Clk(Clk), .Reset(Reset), .bus(bus0.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] led_of(input logic [31:0] w, input logic [1:0] sel);
    logic [31:0] sh;
    sh = w >> (8 * int'(sel));
    return sh[7:0];
  endfunction

  // Expected behaviour at cycle t after the Start sample, from the range rules alone.
  task automatic check_dut(input int id, input int t, input logic valid, busy, done,
                           err, bv, input logic [31:0] ca, cb, cs,
                           input logic [7:0] led, input logic [4:0] ra, rb);
    int    dwell, p, np, dt, a;
    bit    killed, ev;
    string nm;
    dwell  = (id == 0) ? 4 : 0;
    p      = 2 + dwell;
    np     = (sc_last - sc_first + 2) / 2;
    dt     = sc_err ? 0 : np * p;
    killed = (t >= sc_stop) && (sc_stop - 1 < dt);
    if (t == 0) begin
      exp_cs[id] = 32'd0;
      exp_er[id] = sc_err;
    end
    ev = !sc_err && !killed && t >= 2 && ((t - 2) % p == 0) && ((t - 2) / p < np);
    if (ev) begin
      a = sc_first + 2 * ((t - 2) / p);
      exp_ca[id] = mem[a];
      exp_cb[id] = mem[(a + 1) % 32];
      exp_bv[id] = (a < sc_last);
      exp_cs[id] = exp_cs[id] ^ mem[a] ^ ((a < sc_last) ? mem[(a + 1) % 32] : 32'd0);
    end
    nm = $sformatf("d%0d[%0d..%0d] t%0d", dwell, sc_first, sc_last, t);
    chk({nm, " valid"}, 32'(valid), 32'(ev));
    chk({nm, " busy"}, 32'(busy), 32'(!sc_err && !killed && t < dt));
    chk({nm, " done"}, 32'(done), 32'(!killed && t == dt));
    chk({nm, " err"}, 32'(err), 32'(exp_er[id]));
    chk({nm, " b_valid"}, 32'(bv), 32'(exp_bv[id]));
    chk({nm, " cap_a"}, ca, exp_ca[id]);
    chk({nm, " cap_b"}, cb, exp_cb[id]);
    chk({nm, " checksum"}, cs, exp_cs[id]);
    chk({nm, " led"}, 32'(led), 32'(led_of(c2 ? exp_cb[id] : exp_ca[id], c1)));
    chk({nm, " addr_b"}, 32'(rb), 32'(5'(ra + 5'd1)));
  endtask

  task automatic check_both(input int t);
    check_dut(0, t, bus4.Valid, bus4.Busy, bus4.Done, bus4.Err, bus4.B_Valid,
              bus4.Cap_A, bus4.Cap_B, bus4.Checksum, bus4.LED, bus4.R_Addr_A, bus4.R_Addr_B);
    check_dut(1, t, bus0.Valid, bus0.Busy, bus0.Done, bus0.Err, bus0.B_Valid,
              bus0.Cap_A, bus0.Cap_B, bus0.Checksum, bus0.LED, bus0.R_Addr_A, bus0.R_Addr_B);
  endtask

  task automatic run_scan(input int f, input int l, input int s, input bit junk, input bit ss);
    int tmax;
    sc_first = f;
    sc_last  = l;
    sc_err   = (f > l);
    sc_stop  = s;
    tmax     = sc_err ? 3 : ((l - f + 2) / 2) * 6 + 2;
    @(negedge Clk);
    first_a = 5'(f);
    last_a  = 5'(l);
    start   = 1'b1;
    stop    = ss;
    @(negedge Clk);
    for (int t = 0; t <= tmax; t++) begin
      if (t > 0) @(negedge Clk);
      start = 1'b0;
      stop  = (t == sc_stop - 1);
      c1    = 2'($urandom);
      c2    = 1'($urandom);
      if (junk && !sc_err && t == 1) begin
        start   = 1'b1;
        first_a = 5'($urandom);
      end
      #1;
      check_both(t);
    end
    stop = 1'b0;
  endtask

  task automatic check_zero(input string nm, input logic [31:0] ca, cb, cs,
                            input logic [7:0] led, input logic [4:0] ra, rb,
                            input logic valid, busy, done, err, bv);
    chk({nm, " cap_a"}, ca, 32'd0);
    chk({nm, " cap_b"}, cb, 32'd0);
    chk({nm, " checksum"}, cs, 32'd0);
    chk({nm, " led"}, 32'(led), 32'd0);
    chk({nm, " addr_a"}, 32'(ra), 32'd0);
    chk({nm, " addr_b"}, 32'(rb), 32'd1);
    chk({nm, " flags"}, {27'd0, valid, busy, done, err, bv}, 32'd0);
  endtask

  task automatic check_reset_state(input string nm);
    check_zero({nm, " d4"}, bus4.Cap_A, bus4.Cap_B, bus4.Checksum, bus4.LED, bus4.R_Addr_A,
               bus4.R_Addr_B, bus4.Valid, bus4.Busy, bus4.Done, bus4.Err, bus4.B_Valid);
    check_zero({nm, " d0"}, bus0.Cap_A, bus0.Cap_B, bus0.Checksum, bus0.LED, bus0.R_Addr_A,
               bus0.R_Addr_B, bus0.Valid, bus0.Busy, bus0.Done, bus0.Err, bus0.B_Valid);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      exp_ca[i] = '0;
      exp_cb[i] = '0;
      exp_cs[i] = '0;
      exp_bv[i] = 1'b0;
      exp_er[i] = 1'b0;
    end
  endtask

  logic [7:0] led_tab [4];

  initial begin
    int f, l, s, np;
    Reset   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    first_a = '0;
    last_a  = '0;
    c1      = 2'd3;
    c2      = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    clear_model();
    #12;
    check_reset_state("reset");
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      #1;
      chk("idle busy", 32'(bus4.Busy | bus0.Busy), 32'd0);
      chk("idle valid", 32'(bus4.Valid | bus0.Valid), 32'd0);
    end

    run_scan(0, 3, NONE, 1'b0, 1'b0);
    run_scan(1, 5, NONE, 1'b0, 1'b0);
    run_scan(6, 2, NONE, 1'b0, 1'b0);
    run_scan(30, 31, NONE, 1'b0, 1'b0);
    run_scan(31, 31, NONE, 1'b0, 1'b0);
    run_scan(0, 3, 4, 1'b0, 1'b0);
    run_scan(2, 9, NONE, 1'b1, 1'b1);

    mem[5] = 32'hA1B2C3D4;
    run_scan(5, 5, NONE, 1'b0, 1'b0);
    led_tab[0] = 8'hD4;
    led_tab[1] = 8'hC3;
    led_tab[2] = 8'hB2;
    led_tab[3] = 8'hA1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      c2 = 1'b0;
      c1 = 2'(k);
      #1;
      chk($sformatf("led d4 c1=%0d", k), 32'(bus4.LED), 32'(led_tab[k]));
      chk($sformatf("led d0 c1=%0d", k), 32'(bus0.LED), 32'(led_tab[k]));
    end

    // Asynchronous reset in the middle of a scan.
    @(negedge Clk);
    first_a = 5'd2;
    last_a  = 5'd9;
    start   = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (3) @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    check_reset_state("midscan reset");
    @(negedge Clk);
    Reset = 1'b1;
    clear_model();
    repeat (3) begin
      @(negedge Clk);
      #1;
      chk("post-reset busy", 32'(bus4.Busy | bus0.Busy), 32'd0);
      chk("post-reset done", 32'(bus4.Done | bus0.Done), 32'd0);
    end

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      f = int'($urandom_range(0, 31));
      if ($urandom_range(0, 9) < 8) l = int'($urandom_range(f, 31));
      else l = int'($urandom_range(0, 31));
      s = NONE;
      if (f <= l && $urandom_range(0, 9) < 3) begin
        np = (l - f + 2) / 2;
        s  = int'($urandom_range(2, np * 6 + 1));
      end
      run_scan(f, l, s, 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 SHALL have parameter DWELL, default 4, number of cycles each captured pair is held before the next read (0 allowed).
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Start  input  1  begin a scan when sampled high in IDLE.
REQ-005 SHALL have port Stop  input  1  abort an active scan.
REQ-006 SHALL have port First_Addr  input  5  first register address of the scan.
REQ-007 SHALL have port Last_Addr  input  5  last register address of the scan, inclusive.
REQ-008 SHALL have port R_Addr_A  output  5  register-file read address A (registered).
REQ-009 SHALL have port R_Addr_B  output  5  register-file read address B = R_Addr_A+1 mod 32 (registered).
REQ-010 SHALL have port R_Data_A  input  32  combinational read data for R_Addr_A.
REQ-011 SHALL have port R_Data_B  input  32  combinational read data for R_Addr_B.
REQ-012 SHALL have port C1  input  2  byte select for LED (00 = bits 7:0 ... 11 = bits 31:24).
REQ-013 SHALL have port C2  input  1  LED source select (0 = Cap_A, 1 = Cap_B).
REQ-014 SHALL have port LED  output  8  selected byte of the captured word, combinational from Cap_A/Cap_B, C1, C2.
REQ-015 SHALL have port Cap_A  output  32  last captured R_Data_A; Cap_B  output  32  last captured R_Data_B.
REQ-016 SHALL have ports Valid  output  1  one-cycle pulse per captured pair; B_Valid  output  1  Cap_B lies within the scan range.
REQ-017 SHALL have ports Busy  output  1  scan in progress; Done  output  1  one-cycle pulse at normal completion; Err  output  1  First_Addr > Last_Addr at Start.
REQ-018 SHALL have port Checksum  output  32  XOR of all in-range words read during the current/last scan.

Function
REQ-019 SHALL implement FSM states IDLE, ADDR, CAPTURE, DWELL, DONE.
REQ-020 IDLE: Start=1 with First_Addr <= Last_Addr -> R_Addr_A<=First_Addr, Checksum<=0, Err<=0, -> ADDR; Start=1 with First_Addr > Last_Addr -> Err<=1, Checksum<=0, -> DONE.
REQ-021 ADDR: addresses stable for one cycle (read settle); -> CAPTURE unconditionally.
REQ-022 CAPTURE: Cap_A<=R_Data_A, Cap_B<=R_Data_B, B_Valid<=(R_Addr_A < Last_Addr), Checksum ^= R_Data_A, and ^= R_Data_B only if B in range; Valid=1 in the following cycle; -> DWELL with count DWELL-1, or straight to the advance decision if DWELL=0.
REQ-023 DWELL: decrement count each cycle; at 0, if R_Addr_A+1 >= Last_Addr -> DONE, else R_Addr_A<=R_Addr_A+2 -> ADDR.
REQ-024 Per pair SHALL take exactly 2+DWELL cycles; a scan of N registers SHALL take ceil(N/2)*(2+DWELL) cycles from Start sample to DONE entry.
REQ-025 DONE: Done=1 for exactly one cycle, Busy=0, -> IDLE; Checksum, Cap_A, Cap_B, Err hold until the next Start.
REQ-026 Busy SHALL be 1 in ADDR, CAPTURE, DWELL; 0 in IDLE and DONE.
REQ-027 Start while Busy SHALL be ignored.
REQ-028 Stop=1 in any Busy state SHALL force IDLE at the next edge without asserting Done or Valid; Stop has priority over all same-cycle transitions; Stop in IDLE SHALL be ignored; Start and Stop both high in IDLE -> Start wins.
REQ-029 Address arithmetic SHALL be 5-bit modulo 32; at R_Addr_A=31, R_Addr_B=0 and B_Valid=0.
REQ-030 Address increment SHALL never exceed Last_Addr; no wrap past 31 within a scan.

Reset
REQ-031 Reset low SHALL immediately force IDLE, R_Addr_A=0, R_Addr_B=1, Cap_A=Cap_B=0, Checksum=0, Valid=Done=Busy=Err=B_Valid=0 (hence LED=0), including mid-scan.
REQ-032 After Reset rises the block SHALL remain IDLE until Start is sampled high.

Verification (bench models register file R[i]=i)
REQ-033 First=0, Last=3, DWELL=4, Start pulse -> Valid twice (Cap_A/Cap_B = 0/1 then 2/3), Done 12 cycles after Start sample, Checksum=0x00000000.
REQ-034 First=1, Last=5, DWELL=0 -> three pairs, last pair Cap_A=5 with B_Valid=0, Checksum=0x00000001, Done 6 cycles after Start.
REQ-035 First=6, Last=2 -> Err=1, Done pulse next cycle, Valid never asserted, Checksum=0.
REQ-036 First=30, Last=31 then First=31, Last=31 -> second scan: R_Addr_B=0, B_Valid=0, Checksum=31.
REQ-037 Stop asserted during DWELL of first pair -> IDLE next edge, no Done; Reset low mid-scan -> all outputs zero immediately, LED=0.
REQ-038 R[5]=0xA1B2C3D4 captured as Cap_A: C2=0, C1=00/01/10/11 -> LED=D4/C3/B2/A1.
